// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// owner indices and the default watchdog limit.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_arb_timeout.sv
// Saturating stall counter; raises expire for the single cycle in which the
// count of consecutive stalled strobes reaches TIMEOUT_CYCLES.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                      cnt_d = '0;
    else if (count && cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds the stalls before this one, so LAST means this stall is the limit.
  assign expire = count && !clear && (cnt_q == LAST);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter; grant held for the whole cyc tenure.
// Define WB_ARB_TIMEOUT_EN to add the stall watchdog, DRAIN state and err_o.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            gnt_o
);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_gnt_q, last_gnt_d;

  logic                  own, sel_cyc, sel_stb, sel_we, stb_raw, expire;
  logic [ADDR_WIDTH-1:0] sel_adr;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic [1:0]                 m_ack, m_err;
  logic [1:0][DATA_WIDTH-1:0] m_dat;

  assign own     = (state_q == ST_OWN);
  assign sel_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign sel_stb = owner_q ? m1_stb_i : m0_stb_i;
  assign sel_we  = owner_q ? m1_we_i  : m0_we_i;
  assign sel_adr = owner_q ? m1_adr_i : m0_adr_i;
  assign sel_dat = owner_q ? m1_dat_i : m0_dat_i;
  assign stb_raw = own & sel_stb;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (s_ack_i | ~own),
    .count  (stb_raw & ~s_ack_i),
    .expire (expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_M0;
      last_gnt_q <= OWN_M1;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          owner_d    = ~last_gnt_q;
          last_gnt_d = ~last_gnt_q;
          state_d    = ST_OWN;
        end else if (m0_cyc_i) begin
          owner_d    = OWN_M0;
          last_gnt_d = OWN_M0;
          state_d    = ST_OWN;
        end else if (m1_cyc_i) begin
          owner_d    = OWN_M1;
          last_gnt_d = OWN_M1;
          state_d    = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!sel_cyc)    state_d = ST_IDLE;
        else if (expire) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (!sel_cyc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    gnt_o   = 2'b00;
    m_ack   = 2'b00;
    m_err   = 2'b00;
    m_dat   = '0;
    if (own) begin
      s_cyc_o        = sel_cyc & ~expire;
      s_stb_o        = sel_stb & ~expire;
      s_we_o         = sel_we;
      s_adr_o        = sel_adr;
      s_dat_o        = sel_dat;
      gnt_o[owner_q] = 1'b1;
      m_ack[owner_q] = s_ack_i | expire;
      m_err[owner_q] = expire;
      m_dat[owner_q] = expire ? '0 : s_dat_i;
    end else if (state_q == ST_DRAIN) begin
      gnt_o[owner_q] = 1'b1;
    end
  end

  assign m0_ack_o = m_ack[0];
  assign m1_ack_o = m_ack[1];
  assign m0_err_o = m_err[0];
  assign m1_err_o = m_err[1];
  assign m0_dat_o = m_dat[0];
  assign m1_dat_o = m_dat[1];

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m with TIMEOUT_CYCLES=8; watchdog checks
// follow whether WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [15:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [1:0]  gnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0;
    s_ack_i = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    step(); step();
    rst_n = 1;
    step();
  endtask

  initial begin
    do_reset();
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_scyc", s_cyc_o, 1'b0);
    chk("rst_ack", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'h0);

    // Tie after reset: M0 first, dead cycle, then M1; M0 re-requests and loses the tie.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0100;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0200;
    settle();
    chk("tie_pre_gnt", gnt_o, 2'b00);
    step();
    chk("tie1_gnt", gnt_o, 2'b01);
    chk("tie1_adr", s_adr_o, 16'h0100);
    m0_cyc_i = 0; m0_stb_i = 0;
    settle();
    chk("tie1_rel_scyc", s_cyc_o, 1'b0);
    step();
    chk("handover_idle", gnt_o, 2'b00);
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    chk("tie2_gnt_m1", gnt_o, 2'b10);
    chk("tie2_adr", s_adr_o, 16'h0200);
    chk("tie2_m0_ack", m0_ack_o, 1'b0);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    chk("tie2_idle", gnt_o, 2'b00);
    step();
    chk("pending_m0_gnt", gnt_o, 2'b01);
    idle_inputs();
    step(); step();

    // M0 single write, slave acks two cycles after grant.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 16'h0010; m0_dat_i = 32'hCAFEBABE;
    step();
    chk("wr_gnt", gnt_o, 2'b01);
    chk("wr_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
    chk("wr_adr", s_adr_o, 16'h0010);
    chk("wr_dat", s_dat_o, 32'hCAFEBABE);
    chk("wr_noack", m0_ack_o, 1'b0);
    step();
    s_ack_i = 1;
    settle();
    chk("wr_ack", m0_ack_o, 1'b1);
    chk("wr_m1_ack", m1_ack_o, 1'b0);
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    settle();
    chk("wr_ack_drop", m0_ack_o, 1'b0);
    step();
    chk("wr_idle", gnt_o, 2'b00);

    // M1 read with M0 requesting mid-transfer.
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0020;
    step();
    chk("rd_gnt", gnt_o, 2'b10);
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0044;
    settle();
    chk("rd_hold_adr", s_adr_o, 16'h0020);
    step();
    s_ack_i = 1; s_dat_i = 32'h12345678;
    settle();
    chk("rd_m1_ack", m1_ack_o, 1'b1);
    chk("rd_m1_dat", m1_dat_o, 32'h12345678);
    chk("rd_m0_ack", m0_ack_o, 1'b0);
    chk("rd_m0_dat", m0_dat_o, 32'h0);
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();
    chk("rd_idle", gnt_o, 2'b00);
    chk("rd_idle_m0_ack", m0_ack_o, 1'b0);
    step();
    chk("rd_m0_gnt", gnt_o, 2'b01);
    chk("rd_m0_adr", s_adr_o, 16'h0044);
    idle_inputs();
    step(); step();

    // Stalled slave.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0050; s_dat_i = 32'hDEADBEEF;
    step();
    for (int i = 1; i < 8; i++) begin
      chk("to_pre_ack", m0_ack_o, 1'b0);
      chk("to_pre_scyc", s_cyc_o, 1'b1);
      step();
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("to_ack", m0_ack_o, 1'b1);
    chk("to_err", m0_err_o, 1'b1);
    chk("to_dat", m0_dat_o, 32'h0);
    chk("to_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    chk("to_m1", {m1_ack_o, m1_err_o}, 2'b00);
    step();
    s_ack_i = 1;
    settle();
    chk("drain_ack", {m0_ack_o, m0_err_o}, 2'b00);
    chk("drain_scyc", s_cyc_o, 1'b0);
    step();
    chk("drain_hold", s_cyc_o, 1'b0);
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    step();
    chk("drain_idle", gnt_o, 2'b00);
`else
    for (int i = 0; i < 6; i++) begin
      chk("nto_ack", {m0_ack_o, m0_err_o}, 2'b00);
      chk("nto_scyc", s_cyc_o, 1'b1);
      step();
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    chk("nto_idle", gnt_o, 2'b00);
`endif
    idle_inputs();
    step();

    // Ack on the eighth stall cycle wins over expiry.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0058;
    step();
    for (int i = 1; i < 8; i++) step();
    s_ack_i = 1; s_dat_i = 32'hA5A5A5A5;
    settle();
    chk("edge_ack", m0_ack_o, 1'b1);
    chk("edge_err", m0_err_o, 1'b0);
    chk("edge_dat", m0_dat_o, 32'hA5A5A5A5);
    chk("edge_scyc", s_cyc_o, 1'b1);
    s_ack_i = 0;
    step();
    chk("edge_own", gnt_o, 2'b01);
    chk("edge_cleared", {m0_ack_o, m0_err_o, s_cyc_o}, 3'b001);
    idle_inputs();
    step(); step();

    // Asynchronous reset during an M1 write.
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 16'h0060; m1_dat_i = 32'h0BADF00D;
    step();
    chk("ar_gnt", gnt_o, 2'b10);
    chk("ar_stb", s_stb_o, 1'b1);
    s_ack_i = 1; s_dat_i = 32'h11111111;
    #2 rst_n = 0;
    #1;
    chk("ar_gnt0", gnt_o, 2'b00);
    chk("ar_s", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
    chk("ar_sbus", {s_adr_o, s_dat_o}, 48'h0);
    chk("ar_m1", {m1_ack_o, m1_err_o}, 2'b00);
    chk("ar_m1_dat", m1_dat_o, 32'h0);
    step();
    idle_inputs();
    rst_n = 1;
    step();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    chk("ar_tie_m0", gnt_o, 2'b01);
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
